ls_apb_master: RTL and testbench

- APB initiator that drives the LightSeparator register interface (PADDR/PSEL/PENABLE/PWRITE/PWDATA out, PRDATA in).
- Accepts register read/write commands from a local controller over a valid/ready port and buffers them in a small FIFO.
- Issues commands as strictly ordered APB transfers and returns read data on a one-cycle response strobe.
- Sits between the system controller / test sequencer and the LightSeparator slave.

---
 rtl/ls_apb_master_if.sv | 43 ++++
 rtl/ls_apb_master.sv | 137 +++++++++++++
 tb/tb_ls_apb_master.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ls_apb_master_if.sv
// Command/response port and APB bus of ls_apb_master.
// LS_APB_PREADY_EN adds PREADY to the bus.
interface ls_apb_master_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic                  rsp_valid;
  logic                  rsp_write;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  busy;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic                  PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [DATA_WIDTH-1:0] PRDATA;
`ifdef LS_APB_PREADY_EN
  logic                  PREADY;
`endif

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA,
`ifdef LS_APB_PREADY_EN
    input  PREADY,
`endif
    output cmd_ready, rsp_valid, rsp_write, rsp_rdata, busy,
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA,
`ifdef LS_APB_PREADY_EN
    output PREADY,
`endif
    input  cmd_ready, rsp_valid, rsp_write, rsp_rdata, busy,
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA
  );
endinterface

// File: rtl/ls_apb_master.sv
// APB initiator for the LightSeparator: command FIFO feeding an IDLE/SETUP/ACCESS FSM.
// Optional LS_APB_PREADY_EN: ACCESS waits for PREADY.
module ls_apb_master #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CMD_DEPTH  = 4
) (
  input logic            clk,
  input logic            rst,
  ls_apb_master_if.master bus
);
  localparam int unsigned PW = $clog2(CMD_DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t state_q, state_d;

  logic                  fifo_write [CMD_DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_addr  [CMD_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_wdata [CMD_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count_q, count_d;
  logic                  full, empty, push, pop, complete, xfer_done;

  logic [ADDR_WIDTH-1:0] paddr_q;
  logic [DATA_WIDTH-1:0] pwdata_q, rsp_rdata_q;
  logic                  pwrite_q, psel_q, penable_q;
  logic                  rsp_valid_q, rsp_write_q, busy_q;

  assign full  = (count_q == CW'(CMD_DEPTH));
  assign empty = (count_q == '0);
  assign push  = bus.cmd_valid && !full;

`ifdef LS_APB_PREADY_EN
  assign xfer_done = bus.PREADY;
`else
  assign xfer_done = 1'b1;
`endif

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_write[wr_ptr] <= bus.cmd_write;
      fifo_addr[wr_ptr]  <= bus.cmd_addr;
      fifo_wdata[wr_ptr] <= bus.cmd_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!empty) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (xfer_done) state_d = empty ? IDLE : SETUP;
      default: state_d = IDLE;
    endcase
  end

  // A completing ACCESS pops the next command directly so PSEL stays high.
  always_comb begin
    pop      = 1'b0;
    complete = 1'b0;
    case (state_q)
      IDLE:   pop = !empty;
      ACCESS: begin
        complete = xfer_done;
        pop      = xfer_done && !empty;
      end
      default: ;
    endcase
  end

  // Outputs are registered from next-state so they line up with the FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      if (pop) begin
        paddr_q  <= fifo_addr[rd_ptr];
        pwrite_q <= fifo_write[rd_ptr];
        pwdata_q <= fifo_wdata[rd_ptr];
      end
      psel_q      <= (state_d != IDLE);
      penable_q   <= (state_d == ACCESS);
      rsp_valid_q <= complete;
      if (complete) begin
        rsp_write_q <= pwrite_q;
        rsp_rdata_q <= pwrite_q ? '0 : bus.PRDATA;
      end
      busy_q <= (count_d != '0) || (state_d != IDLE);
    end
  end

  assign bus.cmd_ready = !full;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_write = rsp_write_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.busy      = busy_q;
  assign bus.PADDR     = paddr_q;
  assign bus.PSEL      = psel_q;
  assign bus.PENABLE   = penable_q;
  assign bus.PWRITE    = pwrite_q;
  assign bus.PWDATA    = pwdata_q;
endmodule

// File: tb/tb_ls_apb_master.sv
// Self-checking bench for ls_apb_master: vector table, directed sequences, response scoreboard.
module tb_ls_apb_master;
  logic clk;
  logic rst;
  int n_checks = 0;
  int n_fail   = 0;
  int rsp_count = 0;

  ls_apb_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  ls_apb_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .CMD_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave returns a fixed function of the address.
  function automatic logic [31:0] slave_data(input logic [31:0] a);
    return a ^ 32'h0000_00C7;
  endfunction

  assign bus.PRDATA = slave_data(bus.PADDR);
`ifdef LS_APB_PREADY_EN
  logic pready;
  assign bus.PREADY = pready;
`endif

  typedef struct {
    bit          write;
    logic [31:0] rdata;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    bit          write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus.rsp_valid === 1'b1) begin
      exp_t e;
      rsp_count++;
      if (sb_q.size() == 0) begin
        check("rsp_unexpected", 1, 0);
      end else begin
        e = sb_q.pop_front();
        check("sb_rsp_write", bus.rsp_write, e.write);
        check("sb_rsp_rdata", bus.rsp_rdata, e.rdata);
      end
    end
  end

  task automatic cycle(input bit v, input bit w, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] exp_rd, output bit acc);
    exp_t e;
    @(negedge clk);
    bus.cmd_valid = v;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    #1;
    acc = v && (bus.cmd_ready === 1'b1);
    if (acc) begin
      e.write = w;
      e.rdata = exp_rd;
      sb_q.push_back(e);
    end
  endtask

  task automatic idle();
    bit acc;
    cycle(1'b0, 1'b0, '0, '0, '0, acc);
  endtask

  task automatic send(input bit w, input logic [31:0] a, input logic [31:0] d, output bit acc);
    cycle(1'b1, w, a, d, w ? 32'h0 : slave_data(a), acc);
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      idle();
      done = (bus.busy === 1'b0) && (sb_q.size() == 0);
    end
    check("drain_timeout", done, 1'b1);
  endtask

  task automatic apply_vec(input vec_t v);
    bit acc;
    cycle(1'b1, v.write, v.addr, v.wdata, v.exp_rdata, acc);
    check("vec_accept", acc, 1'b1);
    idle();
    check("e0_psel", bus.PSEL, 1'b0);
    check("e0_busy", bus.busy, 1'b1);
    idle();
    check("setup_psel", bus.PSEL, 1'b1);
    check("setup_penable", bus.PENABLE, 1'b0);
    check("setup_paddr", bus.PADDR, v.addr);
    check("setup_pwrite", bus.PWRITE, v.write);
    if (v.write) check("setup_pwdata", bus.PWDATA, v.wdata);
    idle();
    check("access_psel", bus.PSEL, 1'b1);
    check("access_penable", bus.PENABLE, 1'b1);
    check("access_paddr", bus.PADDR, v.addr);
    check("access_rsp_valid", bus.rsp_valid, 1'b0);
    idle();
    check("rsp_valid", bus.rsp_valid, 1'b1);
    check("rsp_write", bus.rsp_write, v.write);
    check("rsp_rdata", bus.rsp_rdata, v.exp_rdata);
    check("post_psel", bus.PSEL, 1'b0);
    check("post_busy", bus.busy, 1'b0);
    idle();
    check("pulse_once", bus.rsp_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[5];
    bit acc;
    int base, j, first_block;
    bit saw_full;

    vecs[0] = '{write: 1'b1, addr: 32'h0000_0010, wdata: 32'hA5A5_0001, exp_rdata: 32'h0};
    vecs[1] = '{write: 1'b0, addr: 32'h0000_0004, wdata: 32'h0,         exp_rdata: 32'h0000_00C3};
    vecs[2] = '{write: 1'b0, addr: 32'h0000_0100, wdata: 32'h0,         exp_rdata: 32'h0000_01C7};
    vecs[3] = '{write: 1'b1, addr: 32'hFFFF_FFFC, wdata: 32'hFFFF_FFFF, exp_rdata: 32'h0};
    vecs[4] = '{write: 1'b0, addr: 32'hFFFF_FFFC, wdata: 32'h0,         exp_rdata: 32'hFFFF_FF3B};

    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
`ifdef LS_APB_PREADY_EN
    pready = 1'b1;
`endif
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("rst_cmd_ready", bus.cmd_ready, 1'b1);
    check("rst_psel", bus.PSEL, 1'b0);
    check("rst_penable", bus.PENABLE, 1'b0);
    check("rst_paddr", bus.PADDR, 32'h0);
    check("rst_pwdata", bus.PWDATA, 32'h0);
    check("rst_pwrite", bus.PWRITE, 1'b0);
    check("rst_rsp_valid", bus.rsp_valid, 1'b0);
    check("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    check("rst_busy", bus.busy, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Single transfers, including test plan items 1 and 2.
    foreach (vecs[i]) apply_vec(vecs[i]);

    // Back-to-back: PSEL high for 8 samples, PENABLE alternating.
    for (int k = 0; k < 12; k++) begin
      case (k)
        0: send(1'b1, 32'h0, 32'hC0DE_0000, acc);
        1: send(1'b0, 32'h4, 32'h0, acc);
        2: send(1'b1, 32'h8, 32'hC0DE_0008, acc);
        3: send(1'b0, 32'hC, 32'h0, acc);
        default: begin idle(); acc = 1'b1; end
      endcase
      check("b2b_accept", acc, 1'b1);
      if (k >= 1 && k <= 10) begin
        check("b2b_psel", bus.PSEL, (k >= 2 && k <= 9));
        check("b2b_penable", bus.PENABLE, (k >= 2 && k <= 9 && (k % 2 == 1)));
      end
    end
    wait_idle();

    // Backpressure: 8 commands, FIFO fills after seven accepted pushes.
    base = rsp_count;
    j = 0;
    first_block = -1;
    saw_full = 1'b0;
    for (int c = 0; c < 60 && j < 8; c++) begin
      send(j % 2 == 0, 32'h40 + 32'(4 * j), 32'hB000_0000 + 32'(j), acc);
      if (acc) j++;
      else begin
        if (!saw_full) first_block = c;
        saw_full = 1'b1;
      end
    end
    check("bp_accepted", j, 8);
    check("bp_saw_full", saw_full, 1'b1);
    check("bp_first_block", first_block, 7);
    wait_idle();
    check("bp_rsp_count", rsp_count - base, 8);

    // Reset during ACCESS of a read with two commands queued.
    send(1'b0, 32'h30, 32'h0, acc);
    send(1'b1, 32'h34, 32'h1234_5678, acc);
    send(1'b0, 32'h38, 32'h0, acc);
    idle();
    check("mid_access_penable", bus.PENABLE, 1'b1);
    check("mid_access_pwrite", bus.PWRITE, 1'b0);
    base = rsp_count;
    rst = 1'b1;
    #1;
    check("arst_psel", bus.PSEL, 1'b0);
    check("arst_penable", bus.PENABLE, 1'b0);
    check("arst_busy", bus.busy, 1'b0);
    check("arst_cmd_ready", bus.cmd_ready, 1'b1);
    check("arst_rsp_valid", bus.rsp_valid, 1'b0);
    sb_q.delete();
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) idle();
    check("arst_no_rsp", rsp_count - base, 0);
    check("arst_busy_after", bus.busy, 1'b0);
    apply_vec('{write: 1'b1, addr: 32'h50, wdata: 32'h5A5A_5A5A, exp_rdata: 32'h0});

`ifdef LS_APB_PREADY_EN
    // PREADY low for the first three ACCESS cycles of a read.
    pready = 1'b0;
    send(1'b0, 32'h20, 32'h0, acc);
    for (int k = 1; k <= 7; k++) begin
      idle();
      if (k >= 3 && k <= 6) begin
        check("wait_penable", bus.PENABLE, 1'b1);
        check("wait_paddr", bus.PADDR, 32'h20);
        check("wait_no_rsp", bus.rsp_valid, 1'b0);
      end
      if (k == 6) pready = 1'b1;
      if (k == 7) begin
        check("wait_rsp_valid", bus.rsp_valid, 1'b1);
        check("wait_rsp_rdata", bus.rsp_rdata, 32'h0000_00E7);
        check("wait_post_psel", bus.PSEL, 1'b0);
      end
    end
    wait_idle();
`endif

    check("sb_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
